// File: rtl/fixed_point_iter_ctrl.sv
// Bounded fixed-point sequencer for x(t+1)=f(x(t)) with an external function unit (req/ack).
// Define FPC_CYCLE2_DETECT_EN to also stop on period-2 oscillation (x(t+1)==x(t-1)).
module fixed_point_iter_ctrl #(
    parameter int W        = 8,
    parameter int MAX_ITER = 255,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [W-1:0]     seed,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic             timeout,
    output logic             cycle2,
    output logic [W-1:0]     result,
    output logic [CNT_W-1:0] iter_count,
    output logic             f_req,
    output logic [W-1:0]     f_arg,
    input  logic             f_ack,
    input  logic [W-1:0]     f_res
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    state_t           state_q, state_d;
    logic [W-1:0]     x_q, x_d;
    logic [W-1:0]     result_q, result_d;
    logic [CNT_W-1:0] iter_count_q, iter_count_d;
    logic             converged_q, converged_d;
    logic             timeout_q, timeout_d;
    logic             cycle2_q, cycle2_d;

    logic [CNT_W-1:0] cnt_inc;
    logic             ack_take;
    logic             hit_conv;
    logic             hit_cyc2;
    logic             hit_tmo;

    assign cnt_inc  = iter_count_q + 1'b1;
    assign ack_take = (state_q == S_WAIT) && !abort && f_ack;
    assign hit_conv = (f_res == x_q);
    assign hit_tmo  = (cnt_inc == MAX_CNT);

`ifdef FPC_CYCLE2_DETECT_EN
    logic [W-1:0] xprev_q, xprev_d;
    logic         prev_valid_q, prev_valid_d;

    assign hit_cyc2 = prev_valid_q && (f_res == xprev_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            xprev_q      <= '0;
            prev_valid_q <= 1'b0;
        end else begin
            xprev_q      <= xprev_d;
            prev_valid_q <= prev_valid_d;
        end
    end

    always_comb begin
        xprev_d      = xprev_q;
        prev_valid_d = prev_valid_q;
        if (state_q == S_IDLE && start) begin
            prev_valid_d = 1'b0;
        end else if (ack_take && !hit_conv && !hit_tmo) begin
            xprev_d      = x_q;
            prev_valid_d = 1'b1;
        end
    end
`else
    assign hit_cyc2 = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            x_q          <= '0;
            result_q     <= '0;
            iter_count_q <= '0;
            converged_q  <= 1'b0;
            timeout_q    <= 1'b0;
            cycle2_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            result_q     <= result_d;
            iter_count_q <= iter_count_d;
            converged_q  <= converged_d;
            timeout_q    <= timeout_d;
            cycle2_q     <= cycle2_d;
        end
    end

    // abort outranks f_ack, so WAIT checks it before looking at the ack
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_ISSUE;
            S_ISSUE: state_d = abort ? S_IDLE : S_WAIT;
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (f_ack) begin
                    state_d = (hit_conv || hit_cyc2 || hit_tmo) ? S_DONE : S_ISSUE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        x_d          = x_q;
        result_d     = result_q;
        iter_count_d = iter_count_q;
        converged_d  = converged_q;
        timeout_d    = timeout_q;
        cycle2_d     = cycle2_q;
        if (state_q == S_IDLE && start) begin
            x_d          = seed;
            iter_count_d = '0;
            converged_d  = 1'b0;
            timeout_d    = 1'b0;
            cycle2_d     = 1'b0;
        end else if (ack_take) begin
            iter_count_d = cnt_inc;
            if (hit_conv) begin
                converged_d = 1'b1;
                result_d    = x_q;
            end else if (hit_cyc2) begin
                cycle2_d = 1'b1;
                result_d = f_res;
            end else if (hit_tmo) begin
                timeout_d = 1'b1;
                result_d  = f_res;
            end else begin
                x_d = f_res;
            end
        end
    end

    always_comb begin
        busy       = (state_q == S_ISSUE) || (state_q == S_WAIT);
        done       = (state_q == S_DONE);
        f_req      = (state_q == S_ISSUE);
        f_arg      = x_q;
        converged  = converged_q;
        timeout    = timeout_q;
        result     = result_q;
        iter_count = iter_count_q;
`ifdef FPC_CYCLE2_DETECT_EN
        cycle2     = cycle2_q;
`else
        cycle2     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_fixed_point_iter_ctrl.sv
// Directed bench: two controller instances (budget 255 and 16) with a variable-latency function-unit model.
module tb_fixed_point_iter_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_a = 1'b0, start_b = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] seed = 8'h00;

    logic       busy_a, done_a, conv_a, tmo_a, cyc2_a, freq_a, ack_a;
    logic [7:0] result_a, cnt_a, farg_a, res_a;
    logic       busy_b, done_b, conv_b, tmo_b, cyc2_b, freq_b, ack_b;
    logic [7:0] result_b, cnt_b, farg_b, res_b;

    always #5 clk = ~clk;

    fixed_point_iter_ctrl #(.W(8), .MAX_ITER(255), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort), .seed(seed),
        .busy(busy_a), .done(done_a), .converged(conv_a), .timeout(tmo_a),
        .cycle2(cyc2_a), .result(result_a), .iter_count(cnt_a),
        .f_req(freq_a), .f_arg(farg_a), .f_ack(ack_a), .f_res(res_a)
    );

    fixed_point_iter_ctrl #(.W(8), .MAX_ITER(16), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort), .seed(seed),
        .busy(busy_b), .done(done_b), .converged(conv_b), .timeout(tmo_b),
        .cycle2(cyc2_b), .result(result_b), .iter_count(cnt_b),
        .f_req(freq_b), .f_arg(farg_b), .f_ack(ack_b), .f_res(res_b)
    );

    int fmode = 0;
    int lat   = 1;

    function automatic logic [7:0] f_model(input int m, input logic [7:0] x);
        case (m)
            0:       return x >> 1;
            1:       return x;
            2:       return x + 8'd1;
            default: return ~x;
        endcase
    endfunction

    // function unit: ack arrives lat cycles after the f_req cycle
    logic       pend_a = 1'b0, pend_b = 1'b0;
    int         wait_a = 0, wait_b = 0;
    logic [7:0] arg_a = 8'h00, arg_b = 8'h00;

    initial begin
        ack_a = 1'b0; res_a = 8'h00;
        ack_b = 1'b0; res_b = 8'h00;
    end

    always @(posedge clk) begin
        ack_a <= 1'b0;
        if (pend_a) begin
            if (wait_a <= 1) begin
                ack_a <= 1'b1; res_a <= f_model(fmode, arg_a); pend_a <= 1'b0;
            end else wait_a <= wait_a - 1;
        end
        if (freq_a) begin
            if (lat <= 1) begin
                ack_a <= 1'b1; res_a <= f_model(fmode, farg_a);
            end else begin
                pend_a <= 1'b1; wait_a <= lat - 1; arg_a <= farg_a;
            end
        end
    end

    always @(posedge clk) begin
        ack_b <= 1'b0;
        if (pend_b) begin
            if (wait_b <= 1) begin
                ack_b <= 1'b1; res_b <= f_model(fmode, arg_b); pend_b <= 1'b0;
            end else wait_b <= wait_b - 1;
        end
        if (freq_b) begin
            if (lat <= 1) begin
                ack_b <= 1'b1; res_b <= f_model(fmode, farg_b);
            end else begin
                pend_b <= 1'b1; wait_b <= lat - 1; arg_b <= farg_b;
            end
        end
    end

    logic       sel = 1'b0;
    logic       o_busy, o_done, o_conv, o_tmo, o_cyc2, o_freq;
    logic [7:0] o_result, o_cnt, o_farg;
    assign o_busy   = sel ? busy_b   : busy_a;
    assign o_done   = sel ? done_b   : done_a;
    assign o_conv   = sel ? conv_b   : conv_a;
    assign o_tmo    = sel ? tmo_b    : tmo_a;
    assign o_cyc2   = sel ? cyc2_b   : cyc2_a;
    assign o_freq   = sel ? freq_b   : freq_a;
    assign o_result = sel ? result_b : result_a;
    assign o_cnt    = sel ? cnt_b    : cnt_a;
    assign o_farg   = sel ? farg_b   : farg_a;

    typedef struct packed {
        logic       conv;
        logic       tmo;
        logic       cyc2;
        logic [7:0] res;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input logic v);
        if (sel) start_b = v; else start_a = v;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},   32'(o_busy),   0);
        chk({tag, "_done"},   32'(o_done),   0);
        chk({tag, "_conv"},   32'(o_conv),   0);
        chk({tag, "_tmo"},    32'(o_tmo),    0);
        chk({tag, "_cyc2"},   32'(o_cyc2),   0);
        chk({tag, "_freq"},   32'(o_freq),   0);
        chk({tag, "_result"}, 32'(o_result), 0);
        chk({tag, "_cnt"},    32'(o_cnt),    0);
        chk({tag, "_farg"},   32'(o_farg),   0);
    endtask

    task automatic run(input string tag, input logic s, input int m, input logic [7:0] sd,
                       input int l, input int max_it, input bit poke_done);
        exp_t       e, g;
        logic [7:0] x, xp, y;
        int         n;
        bit         fin, got;
        sel = s; fmode = m; lat = l;
        x = sd; xp = 8'h00; n = 0; fin = 0; e = '0;
        while (!fin) begin
            y = f_model(m, x);
            n++;
            if (y == x) begin
                e.conv = 1'b1; e.res = x; fin = 1;
            end
`ifdef FPC_CYCLE2_DETECT_EN
            else if (n >= 2 && y == xp) begin
                e.cyc2 = 1'b1; e.res = y; fin = 1;
            end
`endif
            else if (n == max_it) begin
                e.tmo = 1'b1; e.res = y; fin = 1;
            end else begin
                xp = x; x = y;
            end
        end
        e.cnt = 8'(n);
        sb.push_back(e);

        @(negedge clk);
        seed = sd;
        drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        seed = 8'h99;
        chk({tag, "_busy_running"}, 32'(o_busy), 1);
        got = 0;
        for (int i = 0; i < 5000 && !got; i++) begin
            if (o_done) got = 1;
            else @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(got), 1);
        g = sb.pop_front();
        chk({tag, "_converged"},  32'(o_conv),   32'(g.conv));
        chk({tag, "_timeout"},    32'(o_tmo),    32'(g.tmo));
        chk({tag, "_cycle2"},     32'(o_cyc2),   32'(g.cyc2));
        chk({tag, "_result"},     32'(o_result), 32'(g.res));
        chk({tag, "_iter_count"}, 32'(o_cnt),    32'(g.cnt));
        chk({tag, "_busy_in_done"}, 32'(o_busy), 0);
        if (poke_done) drive_start(1'b1);
        @(negedge clk);
        drive_start(1'b0);
        chk({tag, "_done_width"}, 32'(o_done), 0);
        if (poke_done) chk({tag, "_start_in_done_ignored"}, 32'(o_busy), 0);
        chk({tag, "_result_held"}, 32'(o_result), 32'(g.res));
    endtask

    initial begin
        int  nreq;
        bit  saw_done;

        sel = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("reset_a");
        sel = 1'b1;
        check_reset_vals("reset_b");
        rst = 1'b0;
        @(negedge clk);

        run("shift_a0",      1'b0, 0, 8'hA0, 1, 255, 0);
        run("identity_3c",   1'b0, 1, 8'h3C, 1, 255, 1);
        run("inc_budget16",  1'b1, 2, 8'h10, 1, 16,  0);
        run("shift_lat3_b",  1'b1, 0, 8'hA0, 3, 16,  0);
        run("not_0f",        1'b0, 3, 8'h0F, 1, 255, 0);

        // abort in the WAIT of iteration 3 with a 5-cycle function unit
        sel = 1'b0; fmode = 2; lat = 5;
        @(negedge clk);
        seed = 8'h10; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        nreq = 0;
        for (int i = 0; i < 200 && nreq < 3; i++) begin
            if (o_freq) nreq++;
            if (nreq < 3) @(negedge clk);
        end
        chk("abort_third_req_seen", 32'(nreq), 3);
        @(negedge clk);
        seed = 8'h99; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("busy_start_ignored_farg", 32'(o_farg), 32'h12);
        chk("busy_start_still_busy",   32'(o_busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy",      32'(o_busy), 0);
        chk("abort_done",      32'(o_done), 0);
        chk("abort_iter_count", 32'(o_cnt), 2);
        chk("abort_converged", 32'(o_conv), 0);
        chk("abort_timeout",   32'(o_tmo),  0);
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_done || o_busy) saw_done = 1;
        end
        chk("abort_late_ack_ignored", 32'(saw_done), 0);
        chk("abort_count_held",       32'(o_cnt), 2);

        run("after_abort_shift", 1'b0, 0, 8'hA0, 5, 255, 0);

        // synchronous reset in the middle of WAIT
        sel = 1'b0; fmode = 0; lat = 5;
        @(negedge clk);
        seed = 8'hA0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        nreq = 0;
        for (int i = 0; i < 50 && nreq < 2; i++) begin
            if (o_freq) nreq++;
            if (nreq < 2) @(negedge clk);
        end
        chk("rst_second_req_seen", 32'(nreq), 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals("rst_mid_wait");
        rst = 1'b0;
        saw_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (o_done || o_busy) saw_done = 1;
        end
        chk("rst_pending_ack_ignored", 32'(saw_done), 0);
        chk("rst_count_stays_zero",    32'(o_cnt), 0);

        run("after_rst_identity", 1'b0, 1, 8'h55, 2, 255, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
